// File: rtl/sine_sched_pkg.sv
// Shared types and helpers for the time-multiplexed sine voice scheduler:
// FSM states, the ROM-read tag, the frame-length formula and the phase fold.
package sine_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // Widest phase the fold helpers accept; voice ids cover up to 16 voices.
  localparam int MAX_PHASE = 32;
  localparam int VOICE_W   = 4;

  typedef logic [$clog2(MAX_PHASE)-1:0] bit_idx_t;

  // Travels alongside each table read so the capture stage knows what to do.
  typedef struct packed {
    logic               valid;
    logic               neg;
    logic               en;
    logic [VOICE_W-1:0] voice;
  } tag_t;

  // Cycles from the strobe edge to the edge that raises out_valid.
  function automatic int frame_len(input int nvoices, input int rom_latency);
    return nvoices + rom_latency + 2;
  endfunction

  localparam int DEFAULT_FRAME_LEN = frame_len(4, 1);

  // Quarter-wave fold: the second-highest phase bit selects the mirrored
  // (descending) half of the quarter, the next tsize bits address the table.
  function automatic logic [MAX_PHASE-1:0] fold_index(
    input logic [MAX_PHASE-1:0] phase,
    input int                   psize,
    input int                   tsize
  );
    logic [MAX_PHASE-1:0] idx;
    logic                 mirror;
    idx    = '0;
    mirror = phase[bit_idx_t'(psize - 2)];
    for (int k = 0; k < MAX_PHASE; k++) begin
      if (k < tsize) idx[k] = phase[bit_idx_t'(psize - 2 - tsize + k)] ^ mirror;
    end
    return idx;
  endfunction

  // The top phase bit selects the negative half-wave.
  function automatic logic fold_negate(
    input logic [MAX_PHASE-1:0] phase,
    input int                   psize
  );
    return phase[bit_idx_t'(psize - 1)];
  endfunction

endpackage

// File: rtl/sine_phase_fold.sv
// Combinational phase-to-quarter-table mapping: table index plus negate flag.
// Usable by any generator built around a quarter-wave magnitude table.
module sine_phase_fold
  import sine_sched_pkg::*;
#(
  parameter int PHASESIZE = 16,
  parameter int TABLESIZE = 9
) (
  input  logic [PHASESIZE-1:0] phase,
  output logic [TABLESIZE-1:0] index,
  output logic                 negate
);

  logic [MAX_PHASE-1:0] wide_phase;

  assign wide_phase = MAX_PHASE'(phase);

  always_comb begin
    index  = TABLESIZE'(fold_index(wide_phase, PHASESIZE, TABLESIZE));
    negate = fold_negate(wide_phase, PHASESIZE);
  end

endmodule

// File: rtl/sine_voice_scheduler.sv
// Shares one registered quarter-wave sine ROM among NVOICES oscillators,
// one table read per cycle, and publishes all samples with one valid pulse.
// Build option PHASE_SYNC_EN adds a per-voice phase_sync restart input.
module sine_voice_scheduler
  import sine_sched_pkg::*;
#(
  parameter int BITSIZE     = 24,
  parameter int PHASESIZE   = 16,
  parameter int TABLESIZE   = 9,
  parameter int NVOICES     = 4,
  parameter int ROM_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_strobe,
  input  logic [NVOICES*PHASESIZE-1:0] freq,
  input  logic [NVOICES-1:0]           enable,
`ifdef PHASE_SYNC_EN
  input  logic [NVOICES-1:0]           phase_sync,
`endif
  output logic [TABLESIZE-1:0]         table_index,
  input  logic [BITSIZE-1:0]           table_data,
  output logic [NVOICES*BITSIZE-1:0]   out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CNT_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     issue_cnt;
  logic [PHASESIZE-1:0] phase [NVOICES];
  tag_t                 tag_pipe [ROM_LATENCY+1];

  logic [PHASESIZE-1:0] issue_phase;
  logic                 issue_en;
  logic [TABLESIZE-1:0] fold_idx;
  logic                 fold_neg;
  tag_t                 new_tag;
  tag_t                 cap;
  logic                 start;
  logic                 issuing;
  logic                 last_issue;
  logic                 last_capture;

  // Tag leaving the pipeline lines up with the table_data for that voice.
  assign cap          = tag_pipe[ROM_LATENCY];
  assign last_issue   = (issue_cnt == CNT_W'(NVOICES - 1));
  assign last_capture = cap.valid && (cap.voice == VOICE_W'(NVOICES - 1));

  always_comb begin
    issue_phase = phase[0];
    issue_en    = enable[0];
    for (int v = 1; v < NVOICES; v++) begin
      if (issue_cnt == CNT_W'(v)) begin
        issue_phase = phase[v];
        issue_en    = enable[v];
      end
    end
  end

  sine_phase_fold #(
    .PHASESIZE(PHASESIZE),
    .TABLESIZE(TABLESIZE)
  ) u_fold (
    .phase (issue_phase),
    .index (fold_idx),
    .negate(fold_neg)
  );

  always_comb begin
    new_tag       = '0;
    new_tag.valid = issuing;
    new_tag.neg   = fold_neg;
    new_tag.en    = issue_en;
    new_tag.voice = VOICE_W'(issue_cnt);
  end

  // NOTE: every output of a combinational process gets a default before the
  // case, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    issuing = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_strobe) begin
          start   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issuing = 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_capture) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt   <= '0;
      table_index <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      // NOTE: the phase array is small and its reset value is architectural
      // (voices restart from phase 0), so it is reset like ordinary flops.
      for (int v = 0; v < NVOICES; v++) phase[v] <= '0;
      for (int s = 0; s <= ROM_LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_q == DONE);

      if (sample_strobe && busy) overrun <= 1'b1;

      if (start) begin
        busy      <= 1'b1;
        issue_cnt <= '0;
        for (int v = 0; v < NVOICES; v++) begin
`ifdef PHASE_SYNC_EN
          phase[v] <= phase_sync[v] ? freq[v*PHASESIZE +: PHASESIZE]
                                    : phase[v] + freq[v*PHASESIZE +: PHASESIZE];
`else
          phase[v] <= phase[v] + freq[v*PHASESIZE +: PHASESIZE];
`endif
        end
      end

      if (state_q == DONE) busy <= 1'b0;

      if (issuing) begin
        table_index <= fold_idx;
        issue_cnt   <= issue_cnt + 1'b1;
      end

      tag_pipe[0] <= new_tag;
      for (int s = 1; s <= ROM_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];

      for (int v = 0; v < NVOICES; v++) begin
        if (cap.valid && (cap.voice == VOICE_W'(v))) begin
          out[v*BITSIZE +: BITSIZE] <= !cap.en ? '0
                                     : (cap.neg ? -table_data : table_data);
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Scoreboard bench for sine_voice_scheduler with a table[k] = k registered ROM.
module tb_sine_voice_scheduler;
  import sine_sched_pkg::*;

  localparam int B   = 24;
  localparam int P   = 16;
  localparam int T   = 9;
  localparam int N   = 4;
  localparam int L   = 1;
  localparam int LAT = frame_len(N, L);

  logic             clk = 1'b0;
  logic             rst;
  logic             sample_strobe;
  logic [N*P-1:0]   freq;
  logic [N-1:0]     enable;
  logic [N-1:0]     sync_bits;
  logic [T-1:0]     table_index;
  logic [B-1:0]     table_data;
  logic [N*B-1:0]   out;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  always #5 clk = ~clk;

  sine_voice_scheduler #(
    .BITSIZE(B), .PHASESIZE(P), .TABLESIZE(T), .NVOICES(N), .ROM_LATENCY(L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_strobe(sample_strobe),
    .freq         (freq),
    .enable       (enable),
`ifdef PHASE_SYNC_EN
    .phase_sync   (sync_bits),
`endif
    .table_index  (table_index),
    .table_data   (table_data),
    .out          (out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // ROM model: one-cycle registered read of table[k] = k.
  always @(posedge clk) table_data <= B'(table_index);

  int pos_cnt = 0;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  typedef struct {
    logic [N*B-1:0] vals;
    int             due_edge;
  } exp_t;

  exp_t           sb[$];
  exp_t           mon_e;
  int             compared   = 0;
  int             mismatched = 0;
  int             valid_cnt  = 0;
  logic [P-1:0]   m_phase [N];

  // Reference sample from phase arithmetic: quarter position, mirrored or not.
  function automatic logic [B-1:0] model_sample(input logic [P-1:0] ph, input logic en);
    int base, idx;
    base = (int'(ph) >> (P - 2 - T)) % (1 << T);
    idx  = ph[P-2] ? ((1 << T) - 1 - base) : base;
    if (!en) return '0;
    return ph[P-1] ? B'(-idx) : B'(idx);
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: out_valid at edge %0d with no frame pending", pos_cnt);
      end else begin
        mon_e = sb.pop_front();
        for (int v = 0; v < N; v++) begin
          compared++;
          if (out[v*B +: B] !== mon_e.vals[v*B +: B]) begin
            mismatched++;
            $display("FAIL frame_voice%0d: got %h expected %h", v, out[v*B +: B], mon_e.vals[v*B +: B]);
          end
        end
        compared++;
        if (pos_cnt !== mon_e.due_edge) begin
          mismatched++;
          $display("FAIL valid_latency: valid at edge %0d expected edge %0d", pos_cnt, mon_e.due_edge);
        end
      end
    end
  end

  // Called at posedge+#1; the strobe is sampled on the following edge.
  task automatic start_frame(input logic [N*P-1:0] f, input logic [N-1:0] en,
                             input logic [N-1:0] sy);
    exp_t e;
    freq          = f;
    enable        = en;
    sync_bits     = sy;
    sample_strobe = 1'b1;
    for (int v = 0; v < N; v++) begin
`ifdef PHASE_SYNC_EN
      m_phase[v] = sy[v] ? f[v*P +: P] : m_phase[v] + f[v*P +: P];
`else
      m_phase[v] = m_phase[v] + f[v*P +: P];
`endif
      e.vals[v*B +: B] = model_sample(m_phase[v], en[v]);
    end
    e.due_edge = pos_cnt + 1 + LAT;
    sb.push_back(e);
    @(posedge clk); #1;
    sample_strobe = 1'b0;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    for (int v = 0; v < N; v++) m_phase[v] = '0;
  endtask

  task automatic test_reset();
    bit ok_busy;
    rst           = 1'b1;
    sample_strobe = 1'b1;
    freq          = {N{16'h1111}};
    enable        = '1;
    repeat (2) @(posedge clk);
    #1;
    sample_strobe = 1'b0;
    compared++; if (out !== '0) begin mismatched++; $display("FAIL reset_out: got %h expected 0", out); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    compared++; if (table_index !== '0) begin mismatched++; $display("FAIL reset_index: got %0d expected 0", table_index); end
    rst = 1'b0;
    @(posedge clk); #1;
    ok_busy = (busy === 1'b0);
    compared++; if (!ok_busy) begin mismatched++; $display("FAIL strobe_with_reset: busy got %b expected 0", busy); end
    for (int v = 0; v < N; v++) m_phase[v] = '0;
  endtask

  task automatic test_basic_fold();
    bit seen;
    start_frame({48'h0, 16'h4020}, 4'b0001, '0);
    wait_valid(seen);
    compared++; if (!seen) begin mismatched++; $display("FAIL basic_timeout: no out_valid within %0d cycles", 3 * LAT); end
    compared++; if (out[B-1:0] !== 24'd510) begin mismatched++; $display("FAIL basic_out0: got %0d expected 510", out[B-1:0]); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    @(posedge clk); #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL valid_pulse_width: got %b expected 0", out_valid); end
  endtask

  task automatic test_negate_wrap();
    bit seen;
    start_frame({48'h0, 16'h4020}, 4'b0001, '0);
    wait_valid(seen);
    compared++; if (!seen) begin mismatched++; $display("FAIL negate_timeout: no out_valid"); end
    compared++; if (out[B-1:0] !== 24'hFFFFFE) begin mismatched++; $display("FAIL negate_out0: got %h expected fffffe", out[B-1:0]); end
    start_frame({48'h0, 16'hC000}, 4'b0001, '0);
    wait_valid(seen);
    compared++; if (!seen) begin mismatched++; $display("FAIL wrap_timeout: no out_valid"); end
    compared++; if (out[B-1:0] !== 24'd509) begin mismatched++; $display("FAIL wrap_out0: got %0d expected 509", out[B-1:0]); end
  endtask

  task automatic test_enable_order();
    bit seen;
    do_reset();
    start_frame({16'h0080, 16'h0060, 16'h0040, 16'h0020}, 4'b1010, '0);
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      compared++;
      if (table_index !== T'(i + 1)) begin
        mismatched++;
        $display("FAIL issue_order_%0d: index got %0d expected %0d", i, table_index, i + 1);
      end
    end
    wait_valid(seen);
    compared++; if (!seen) begin mismatched++; $display("FAIL enable_timeout: no out_valid"); end
    compared++;
    if (out !== {24'd4, 24'd0, 24'd2, 24'd0}) begin
      mismatched++;
      $display("FAIL enable_gating: got %h expected %h", out, {24'd4, 24'd0, 24'd2, 24'd0});
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    for (int k = 0; k < 6; k++) begin
      start_frame({$urandom, $urandom}, N'($urandom), '0);
      wait_valid(seen);
      compared++; if (!seen) begin mismatched++; $display("FAIL b2b_timeout_%0d: no out_valid", k); end
    end
    repeat (2) @(posedge clk);
    #1;
    compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_overrun();
    int base;
    base = valid_cnt;
    start_frame({4{16'h0100}}, 4'b1111, '0);
    repeat (2) @(posedge clk);
    #1;
    sample_strobe = 1'b1;
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    compared++; if (valid_cnt - base !== 1) begin mismatched++; $display("FAIL overrun_pulses: got %0d expected 1", valid_cnt - base); end
    compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    repeat (5) @(posedge clk);
    #1;
    compared++; if (overrun !== 1'b1) begin mismatched++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int  base;
    bit  seen;
    start_frame({4{16'h0123}}, 4'b1111, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    for (int v = 0; v < N; v++) m_phase[v] = '0;
    compared++; if (out !== '0) begin mismatched++; $display("FAIL midrst_out: got %h expected 0", out); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    compared++; if (table_index !== '0) begin mismatched++; $display("FAIL midrst_index: got %0d expected 0", table_index); end
    compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
    rst  = 1'b0;
    base = valid_cnt;
    repeat (12) @(posedge clk);
    #1;
    compared++; if (valid_cnt !== base) begin mismatched++; $display("FAIL midrst_no_valid: got %0d pulses expected 0", valid_cnt - base); end
    start_frame({16'h0080, 16'h0060, 16'h0040, 16'h0020}, 4'b1111, '0);
    wait_valid(seen);
    compared++; if (!seen) begin mismatched++; $display("FAIL midrst_timeout: no out_valid after reset"); end
    compared++;
    if (out !== {24'd4, 24'd3, 24'd2, 24'd1}) begin
      mismatched++;
      $display("FAIL midrst_fresh_frame: got %h expected %h", out, {24'd4, 24'd3, 24'd2, 24'd1});
    end
  endtask

`ifdef PHASE_SYNC_EN
  task automatic test_phase_sync();
    bit seen;
    do_reset();
    start_frame({48'h0, 16'h1234}, 4'b0001, '0);
    wait_valid(seen);
    compared++; if (!seen) begin mismatched++; $display("FAIL sync_setup_timeout: no out_valid"); end
    start_frame({48'h0, 16'h0020}, 4'b0001, 4'b0001);
    wait_valid(seen);
    compared++; if (!seen) begin mismatched++; $display("FAIL sync_timeout: no out_valid"); end
    compared++; if (out[B-1:0] !== 24'd1) begin mismatched++; $display("FAIL sync_out0: got %0d expected 1", out[B-1:0]); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    sample_strobe = 1'b0;
    freq          = '0;
    enable        = '0;
    sync_bits     = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic_fold();
    test_negate_wrap();
    test_enable_order();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
`ifdef PHASE_SYNC_EN
    test_phase_sync();
`endif
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d frames never produced", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
